// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// uart_rx_ctrl : UART receive sequencer (start qualify, mid-bit sample, stop
//                check, valid/ready byte handoff). Rev 1.0
// ============================================================================
module uart_rx_ctrl #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sample,
   input  logic                 data,
   output logic                 shift_en,
   output logic                 shift_bit,
   output logic [DATA_BITS-1:0] rx,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 start,
   output logic                 busy
);

   localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t                 state, state_nx;
   logic                   sync1, rxs;
   logic [TW-1:0]          tcnt, tcnt_nx;
   logic [BW-1:0]          bit_idx, bit_idx_nx;
   logic [DATA_BITS-1:0]   asm_byte, asm_byte_nx;
   logic [DATA_BITS-1:0]   rx_nx;
   logic                   shift_en_nx, shift_bit_nx, rx_valid_nx;
   logic                   frame_err_nx, overrun_nx, start_nx, busy_nx;
   logic                   done;

   // Line is idle-high, so the synchroniser resets to 1 to avoid a fake start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= data;
         rxs   <= sync1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         tcnt      <= '0;
         bit_idx   <= '0;
         asm_byte  <= '0;
         shift_en  <= 1'b0;
         shift_bit <= 1'b0;
         rx        <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         start     <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nx;
         tcnt      <= tcnt_nx;
         bit_idx   <= bit_idx_nx;
         asm_byte  <= asm_byte_nx;
         shift_en  <= shift_en_nx;
         shift_bit <= shift_bit_nx;
         rx        <= rx_nx;
         rx_valid  <= rx_valid_nx;
         frame_err <= frame_err_nx;
         overrun   <= overrun_nx;
         start     <= start_nx;
         busy      <= busy_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      tcnt_nx      = tcnt;
      bit_idx_nx   = bit_idx;
      asm_byte_nx  = asm_byte;
      shift_en_nx  = 1'b0;
      shift_bit_nx = shift_bit;
      rx_nx        = rx;
      rx_valid_nx  = rx_valid;
      frame_err_nx = 1'b0;
      overrun_nx   = 1'b0;
      start_nx     = 1'b0;
      done         = 1'b0;

      if (rx_valid && rx_ready) begin
         rx_valid_nx = 1'b0;
      end

      case (state)
         S_IDLE: begin
            if (!rxs) begin
               state_nx = S_START;
               tcnt_nx  = '0;
            end
         end
         S_START: begin
            if (sample) begin
               if (tcnt == T_MID) begin
                  tcnt_nx = '0;
                  if (rxs) begin
                     state_nx = S_IDLE;
                  end else begin
                     start_nx   = 1'b1;
                     state_nx   = S_DATA;
                     bit_idx_nx = '0;
                  end
               end else begin
                  tcnt_nx = tcnt + TW'(1);
               end
            end
         end
         S_DATA: begin
            if (sample) begin
               if (tcnt == T_END) begin
                  shift_en_nx           = 1'b1;
                  shift_bit_nx          = rxs;
                  asm_byte_nx[bit_idx]  = rxs;
                  tcnt_nx               = '0;
                  if (bit_idx == B_LAST) begin
                     state_nx   = S_STOP;
                     bit_idx_nx = '0;
                  end else begin
                     bit_idx_nx = bit_idx + BW'(1);
                  end
               end else begin
                  tcnt_nx = tcnt + TW'(1);
               end
            end
         end
         S_STOP: begin
            if (sample) begin
               if (tcnt == T_END) begin
                  tcnt_nx = '0;
                  if (rxs) begin
                     done     = 1'b1;
                     state_nx = S_IDLE;
                  end else begin
                     frame_err_nx = 1'b1;
                     state_nx     = S_BREAK;
                  end
               end else begin
                  tcnt_nx = tcnt + TW'(1);
               end
            end
         end
         S_BREAK: begin
            if (rxs) begin
               state_nx = S_IDLE;
               tcnt_nx  = '0;
            end
         end
         default: begin
            state_nx = S_IDLE;
            tcnt_nx  = '0;
         end
      endcase

      // A same-cycle consume frees the holding register for the new byte.
      if (done) begin
         if (!rx_valid || rx_ready) begin
            rx_nx       = asm_byte;
            rx_valid_nx = 1'b1;
         end else begin
            overrun_nx = 1'b1;
         end
      end

      busy_nx = (state_nx != S_IDLE);
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_ctrl : directed self-checking bench for uart_rx_ctrl. Rev 1.0
// ============================================================================
module tb_uart_rx_ctrl;

   localparam int BITCLK = 64;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       sample = 1'b0;
   logic       data = 1'b1;
   logic       rx_ready = 1'b0;
   logic       shift_en, shift_bit, rx_valid, frame_err, overrun, start, busy;
   logic [7:0] rx;

   int checks = 0;
   int errors = 0;
   int n_shift = 0, n_ferr = 0, n_ovr = 0, n_start = 0;
   logic [7:0] shift_log = 8'h00;
   int sc = 0;
   int s0, st0, fe0, ov0;
   int hs_seen, hs_guard;

   uart_rx_ctrl #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .sample    (sample),
      .data      (data),
      .shift_en  (shift_en),
      .shift_bit (shift_bit),
      .rx        (rx),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .start     (start),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Sample tick every 4 clks.
   initial begin
      forever begin
         @(negedge clk);
         sc = sc + 1;
         sample = (sc % 4 == 0);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (shift_en) begin
            n_shift   = n_shift + 1;
            shift_log = {shift_bit, shift_log[7:1]};
         end
         if (frame_err) n_ferr  = n_ferr + 1;
         if (overrun)   n_ovr   = n_ovr + 1;
         if (start)     n_start = n_start + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks = checks + 1;
      assert (obs === exp_v) else begin
         errors = errors + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_val);
      @(negedge clk);
      data = 1'b0;
      repeat (BITCLK) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         data = b[i];
         repeat (BITCLK) @(negedge clk);
      end
      data = stop_val;
      repeat (BITCLK) @(negedge clk);
   endtask

   task automatic consume();
      @(negedge clk);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic wait_shifts(input int n);
      hs_seen  = 0;
      hs_guard = 0;
      while (hs_seen < n && hs_guard < 2000) begin
         @(negedge clk);
         hs_guard = hs_guard + 1;
         if (shift_en) hs_seen = hs_seen + 1;
      end
      chk("shift_wait", hs_seen, n);
   endtask

   initial begin
      // Reset state
      repeat (5) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx", rx, 0);
      chk("rst_shift_en", shift_en, 0);
      chk("rst_pulses", {frame_err, overrun, start, shift_bit}, 0);
      reset = 1'b1;
      repeat (10) @(negedge clk);

      // 0xA5 with rx_ready low
      s0 = n_shift; st0 = n_start; fe0 = n_ferr; ov0 = n_ovr;
      send_frame(8'hA5, 1'b1);
      repeat (16) @(negedge clk);
      chk("a5_shift_count", n_shift - s0, 8);
      chk("a5_shift_bits", shift_log, 8'hA5);
      chk("a5_rx", rx, 8'hA5);
      chk("a5_rx_valid", rx_valid, 1);
      chk("a5_ferr", n_ferr - fe0, 0);
      chk("a5_ovr", n_ovr - ov0, 0);
      chk("a5_start", n_start - st0, 1);
      chk("a5_busy", busy, 0);
      consume();
      chk("a5_consumed", rx_valid, 0);

      // False start: line low for 5 sample ticks
      st0 = n_start;
      @(negedge clk);
      data = 1'b0;
      repeat (10) @(negedge clk);
      chk("fs_busy_hi", busy, 1);
      repeat (10) @(negedge clk);
      data = 1'b1;
      repeat (60) @(negedge clk);
      chk("fs_busy_lo", busy, 0);
      chk("fs_no_start", n_start - st0, 0);
      chk("fs_rx_valid", rx_valid, 0);

      // 0x3C with low stop bit, held low, then released
      fe0 = n_ferr; st0 = n_start;
      send_frame(8'h3C, 1'b0);
      repeat (BITCLK) @(negedge clk);
      chk("brk_busy", busy, 1);
      chk("brk_one_start", n_start - st0, 1);
      chk("brk_ferr", n_ferr - fe0, 1);
      data = 1'b1;
      repeat (10) @(negedge clk);
      chk("brk_exit", busy, 0);
      chk("brk_rx_valid", rx_valid, 0);
      send_frame(8'h81, 1'b1);
      repeat (16) @(negedge clk);
      chk("f81_rx", rx, 8'h81);
      chk("f81_rx_valid", rx_valid, 1);
      chk("f81_ferr", n_ferr - fe0, 1);
      consume();

      // Overrun: 0x11 then 0x22 with rx_ready low
      ov0 = n_ovr;
      send_frame(8'h11, 1'b1);
      repeat (16) @(negedge clk);
      chk("ovr_first", n_ovr - ov0, 0);
      send_frame(8'h22, 1'b1);
      repeat (16) @(negedge clk);
      chk("ovr_pulse", n_ovr - ov0, 1);
      chk("ovr_rx", rx, 8'h11);
      chk("ovr_rx_valid", rx_valid, 1);
      consume();
      chk("ovr_consumed", rx_valid, 0);

      // 0x55 completing in the same clk as rx_ready, 0x11 pending
      send_frame(8'h11, 1'b1);
      repeat (16) @(negedge clk);
      chk("hs_pending", rx_valid, 1);
      ov0 = n_ovr;
      fork
         send_frame(8'h55, 1'b1);
         begin
            wait_shifts(8);
            // Stop-bit completion is 16 ticks (64 clks) after the last shift.
            repeat (63) @(negedge clk);
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
         end
      join
      repeat (16) @(negedge clk);
      chk("hs_rx", rx, 8'h55);
      chk("hs_rx_valid", rx_valid, 1);
      chk("hs_no_ovr", n_ovr - ov0, 0);

      // Reset during data bit 4 of 0xF0 (0x55 still pending)
      st0 = n_start;
      fork
         send_frame(8'hF0, 1'b1);
         begin
            wait_shifts(4);
            repeat (20) @(negedge clk);
            reset = 1'b0;
            #1;
            chk("ar_busy", busy, 0);
            chk("ar_rx", rx, 0);
            chk("ar_rx_valid", rx_valid, 0);
            chk("ar_pulses", {shift_en, shift_bit, frame_err, overrun, start}, 0);
            repeat (40) @(negedge clk);
            reset = 1'b1;
         end
      join
      repeat (16) @(negedge clk);
      chk("ar_no_deliver", rx_valid, 0);
      chk("ar_idle", busy, 0);
      chk("ar_start_once", n_start - st0, 1);
      send_frame(8'h0F, 1'b1);
      repeat (16) @(negedge clk);
      chk("f0f_rx", rx, 8'h0F);
      chk("f0f_rx_valid", rx_valid, 1);
      chk("f0f_shift_bits", shift_log, 8'h0F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
